// File: rtl/bit_permute_unit_if.sv
// Handshake bundle for the bit permutation unit: input stream and output stream.
interface bit_permute_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_mode;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  // Unit side.
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/bit_permute_unit.sv
// Bit permutation engine: combinational permute of the incoming operand,
// results held in a 2-entry FIFO so a stalled consumer never loses data.
module bit_permute_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  bit_permute_unit_if.slave bus,
  output logic [1:0]        level,
  output logic [CNT_W-1:0]  done_count
);
  localparam int NB = WIDTH / 8;

  typedef struct packed {
    logic [1:0]       mode;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic [NB-1:0][7:0] din, byte_swap, byte_rev;
  logic [WIDTH-1:0]   full_rev, result;
  entry_t             mem [2];
  logic               head, tail;
  logic               push, pop;

  assign din = bus.in_data;

  // Per-byte lanes: swap byte order and mirror bits inside each byte.
  for (genvar k = 0; k < NB; k++) begin : g_byte
    assign byte_swap[k] = din[NB-1-k];
    for (genvar j = 0; j < 8; j++) begin : g_bit
      assign byte_rev[k][j] = din[k][7-j];
    end
  end

  // Whole-word mirror.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign full_rev[i] = bus.in_data[WIDTH-1-i];
  end

  // Mode select for the permutation result.
  always_comb begin
    result = bus.in_data;
    case (bus.in_mode)
      2'b01:   result = full_rev;
      2'b10:   result = byte_swap;
      2'b11:   result = byte_rev;
      default: result = bus.in_data;
    endcase
  end

  // Ready/valid come only from registered occupancy, never from out_ready.
  assign bus.in_ready  = (level != 2'd2);
  assign bus.out_valid = (level != 2'd0);
  assign bus.out_data  = mem[head].data;
  assign bus.out_mode  = mem[head].mode;

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // FIFO storage, pointers, occupancy and transfer counter; reset discards entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      head       <= 1'b0;
      tail       <= 1'b0;
      level      <= 2'd0;
      done_count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= '{mode: bus.in_mode, data: result};
        tail      <= ~tail;
      end
      if (pop) begin
        head       <= ~head;
        done_count <= done_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_permute_unit.sv
// Scoreboard bench: stimulus pushes expected {mode,data}, monitor pops on each output transfer.
module tb_bit_permute_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  level, level8;
  logic [15:0] done_count, done_count8;

  int checks = 0;
  int errors = 0;

  bit_permute_unit_if #(.WIDTH(32)) bus ();
  bit_permute_unit_if #(.WIDTH(8))  bus8 ();

  bit_permute_unit #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .level(level), .done_count(done_count)
  );

  bit_permute_unit #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .level(level8), .done_count(done_count8)
  );

  always #5 clk = ~clk;

  logic [33:0] q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: sample mid-low-phase, after stimulus has settled.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_output", {bus.out_mode, bus.out_data}, 34'h0);
        end else begin
          e = q.pop_front();
          chk("sb_data", bus.out_data, e[31:0]);
          chk("sb_mode", bus.out_mode, e[33:32]);
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [1:0] m, input logic [31:0] exp);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("send_timeout", 0, 1);
    q.push_back({m, exp});
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_mode    = '0;
    bus.out_ready  = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = '0;
    bus8.in_mode   = '0;
    bus8.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_mode", bus.out_mode, 0);
    chk("rst_done_count", done_count, 0);
    rst = 1'b0;

    // Single full reverse, one-cycle latency
    bus.out_ready = 1'b1;
    send(32'h0000_0001, 2'b01, 32'h8000_0000);
    idle();
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_level", level, 1);
    @(negedge clk);
    chk("t1_done_count", done_count, 1);

    // All four modes back-to-back; occupancy stays at 1
    send(32'h1234_5678, 2'b00, 32'h1234_5678);
    send(32'h1234_5678, 2'b01, 32'h1E6A_2C48);
    chk("t2_level_a", level, 1);
    send(32'h1234_5678, 2'b10, 32'h7856_3412);
    chk("t2_level_b", level, 1);
    send(32'h1234_5678, 2'b11, 32'h482C_6A1E);
    chk("t2_level_c", level, 1);
    idle();
    chk("t2_level_d", level, 1);
    drain();
    chk("t2_done_count", done_count, 5);

    // Backpressure: A and B buffered, C held until a pop frees a slot
    bus.out_ready = 1'b0;
    send(32'hA, 2'b00, 32'hA);
    send(32'hB, 2'b00, 32'hB);
    @(negedge clk);
    bus.in_data = 32'hC;
    bus.in_mode = 2'b00;
    chk("t3_level_full", level, 2);
    chk("t3_in_ready_low", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    chk("t3_level_hold", level, 2);
    chk("t3_in_ready_hold", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 20);
    chk("t3_ready_after_pop", n, 1);
    q.push_back({2'b00, 32'hC});
    drain();
    chk("t3_done_count", done_count, 8);
    chk("t3_level_empty", level, 0);

    // Reset at level 2 discards the buffered entries
    bus.out_ready = 1'b0;
    send(32'h1111_1111, 2'b00, 32'h1111_1111);
    send(32'h2222_2222, 2'b00, 32'h2222_2222);
    idle();
    chk("t4_level_pre", level, 2);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("t4_level", level, 0);
    chk("t4_out_valid", bus.out_valid, 0);
    chk("t4_in_ready", bus.in_ready, 1);
    chk("t4_done_count", done_count, 0);
    bus.out_ready = 1'b1;
    send(32'hAABB_CCDD, 2'b10, 32'hDDCC_BBAA);
    drain();
    chk("t4_done_after", done_count, 1);

    // Counter wrap: 65536 transfers return to 0, one more reads 1
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) send(i, 2'b00, i);
    drain();
    chk("t5_wrap_zero", done_count, 0);
    send(32'h5, 2'b00, 32'h5);
    drain();
    chk("t5_wrap_one", done_count, 1);

    // 8-bit instance
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.in_data  = 8'h01;
    bus8.in_mode  = 2'b11;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    chk("w8_valid_a", bus8.out_valid, 1);
    chk("w8_data_a", bus8.out_data, 8'h80);
    chk("w8_mode_a", bus8.out_mode, 2'b11);
    @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.in_data  = 8'h5A;
    bus8.in_mode  = 2'b10;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    chk("w8_valid_b", bus8.out_valid, 1);
    chk("w8_data_b", bus8.out_data, 8'h5A);
    chk("w8_mode_b", bus8.out_mode, 2'b10);
    @(negedge clk);
    chk("w8_done_count", done_count8, 2);
    chk("w8_level", level8, 0);

    chk("sb_final_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit_permute_unit.md
# bit_permute_unit

Parametrised, pipelined bit-permutation engine for the integer datapath. It generalises fixed 32-bit operand reversal to any byte-multiple width and selects per transaction between pass-through, full bit reversal, byte swap and per-byte bit reversal. Results pass through a 2-entry output buffer with valid/ready handshakes on both sides. It sits between operand registers and the divider/ALU stages, so a stalled consumer never corrupts or drops an operand.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of 8 and ≥ 8.
- CNT_W, 16, width of the completed-transaction counter.

- clk  input  1  rising-edge clock; sole clock domain.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in_valid  input  1  upstream presents a transaction.
- in_ready  output  1  unit can accept; a transfer occurs when in_valid && in_ready at a clk edge.
- in_data  input  WIDTH  operand.
- in_mode  input  2  00 pass, 01 full bit reverse, 10 byte swap, 11 bit reverse within each byte.
- out_valid  output  1  buffer head holds a result.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- out_data  output  WIDTH  permuted result at the buffer head.
- out_mode  output  2  mode that produced out_data.
- level  output  2  buffer occupancy: 0, 1 or 2.
- done_count  output  CNT_W  number of output transfers, modulo 2^CNT_W.

## Operation
- Permutations, with i the bit index and k the byte index:
  - mode 00: out[i] = in[i].
  - mode 01: out[i] = in[WIDTH-1-i].
  - mode 10: byte k of out = byte (WIDTH/8-1-k) of in.
  - mode 11: out[8k+j] = in[8k+7-j] for j in 0..7.
- Permutation is combinational on in_data/in_mode. The result is written into the buffer only on an input transfer.
- Buffer: 2-entry FIFO, with head and tail each 1 bit and wrapping 1→0. Data is stored as {mode, result}.
- in_ready = (level != 2). It depends only on registered state, with no combinational path from out_ready.
- out_valid = (level != 0). out_data and out_mode are driven from the head entry.
- Occupancy update per cycle:
  - push only: level+1.
  - pop only: level−1.
  - push and pop in the same cycle: level unchanged; the head advances and the new entry is written at the tail.
- Push and pop together at level 1 is legal and sustains one transfer per cycle.
- Push at level 2 is impossible because in_ready is low there.
- Pop at level 0 is impossible because out_valid is low there.
- Ordering is strictly FIFO, and mode travels with its data.
- done_count increments by 1 on each output transfer and wraps from 2^CNT_W−1 to 0.
- Holding in_valid while in_ready is low changes nothing. Upstream must hold its data stable.

## Timing
- Reset values (rst=1 at an edge; effective from the next cycle):
  - level=0, out_valid=0, in_ready=1.
  - out_data=0, out_mode=0, done_count=0.
  - head and tail pointers = 0.
- Reset overrides any simultaneous push or pop. Buffered entries are discarded and not counted.
- Latency: data accepted at edge N appears on out_data with out_valid=1 in the cycle after edge N, provided the buffer was empty.
- Throughput: 1 transaction per cycle with out_ready held high.
- With out_ready low, at most 2 transactions are accepted. in_ready falls in the cycle after the 2nd accept.
- After out_ready rises at level 2, in_ready is high in the cycle after the first pop.
- done_count updates at the same edge as the output transfer.

## Test plan
- WIDTH=32, mode 01, in_data=32'h0000_0001, out_ready=1 → next cycle out_data=32'h8000_0000, out_mode=01, done_count=1.
- 32'h1234_5678 sent back-to-back in modes 00, 01, 10, 11 with out_ready=1 → outputs 32'h1234_5678, 32'h1E6A_2C48, 32'h7856_3412, 32'h482C_6A1E on consecutive cycles; level stays 1.
- out_ready=0; offer A=32'hA, B=32'hB, C=32'hC, all in mode 00 → A and B accepted; level=2, in_ready=0; C held. Raise out_ready → A, B, then C delivered in order; done_count=3.
- Assert rst at level 2 in the middle of a stream → next cycle level=0, out_valid=0, in_ready=1, done_count=0. Then a new mode 10 word 32'hAABB_CCDD → 32'hDDCC_BBAA.
- Run 65537 continuous transfers with CNT_W=16 → done_count wraps to 0 after 65536 and reads 1 at the end.
- Instance with WIDTH=8, mode 11, in_data=8'h01 → 8'h80. Same instance, mode 10, in_data=8'h5A → 8'h5A.
